vend_disp_scan: RTL and testbench

Display back-end for the vending-machine controller. It takes the controller's state-dependent values and drives the 8-digit, common-anode, multiplexed seven-segment display (`Bit_select`/`Seg_select`):

- goods code;
- amount due;
- money inserted;
- change due.

Binary amounts are converted to decimal by a sequential double-dabble converter shared round-robin across three channels. The digit scan uses a programmable prescaler.

---
 rtl/vend_disp_scan.sv | 167 ++++++++++++++++
 tb/tb_vend_disp_scan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vend_disp_scan.sv
// Seven-segment display back-end: round-robin double-dabble conversion of three amounts
// plus a prescaled 8-digit multiplexed scan with registered digit enables and segments.
module vend_disp_scan #(
   parameter int SCAN_DIV = 100000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [1:0] disp_mode,
   input  logic [7:0] goods_code,
   input  logic [7:0] need_money,
   input  logic [7:0] input_money,
   input  logic [7:0] change_money,
   output logic [7:0] Bit_select,
   output logic [7:0] Seg_select
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {LOAD, SHIFT, STORE} cv_state_t;

   cv_state_t   cv_state_q, cv_state_d;
   logic [1:0]  ch_q, ch_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [11:0] bcd_ch_q [3];
   logic [11:0] bcd_ch_d [3];
   logic [11:0] bcd_adj;
   logic [19:0] shifted;

   logic [PW-1:0] presc_q, presc_d;
   logic          presc_tc;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    bit_q, bit_d;
   logic [7:0]    seg_q, seg_d;
   logic [7:0]    pattern;

   function automatic logic [3:0] adj3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [7:0] seg_code(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0;
         4'h1: return 8'hF9;
         4'h2: return 8'hA4;
         4'h3: return 8'hB0;
         4'h4: return 8'h99;
         4'h5: return 8'h92;
         4'h6: return 8'h82;
         4'h7: return 8'hF8;
         4'h8: return 8'h80;
         4'h9: return 8'h90;
         4'hA: return 8'h88;
         4'hB: return 8'h83;
         4'hC: return 8'hC6;
         4'hD: return 8'hA1;
         4'hE: return 8'h86;
         default: return 8'h8E;
      endcase
   endfunction

   // pos 2 = hundreds, 1 = tens, 0 = units; leading zeros blank, units always shown
   function automatic logic [7:0] dec_digit(input logic [11:0] b, input logic [1:0] pos);
      case (pos)
         2'd2:    return (b[11:8] == 4'd0) ? 8'hFF : seg_code(b[11:8]);
         2'd1:    return (b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 8'hFF : seg_code(b[7:4]);
         default: return seg_code(b[3:0]);
      endcase
   endfunction

   always_comb begin
      cv_state_d = cv_state_q;
      ch_d       = ch_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      for (int i = 0; i < 3; i++) bcd_ch_d[i] = bcd_ch_q[i];
      bcd_adj = {adj3(bcd_q[11:8]), adj3(bcd_q[7:4]), adj3(bcd_q[3:0])};
      shifted = {bcd_adj, bin_q} << 1;
      case (cv_state_q)
         LOAD: begin
            case (ch_q)
               2'd0:    bin_d = need_money;
               2'd1:    bin_d = input_money;
               default: bin_d = change_money;
            endcase
            bcd_d      = '0;
            cnt_d      = '0;
            cv_state_d = SHIFT;
         end
         SHIFT: begin
            bcd_d = shifted[19:8];
            bin_d = shifted[7:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) cv_state_d = STORE;
         end
         STORE: begin
            for (int i = 0; i < 3; i++)
               if (ch_q == 2'(i)) bcd_ch_d[i] = bcd_q;
            ch_d       = (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
            cv_state_d = LOAD;
         end
         default: cv_state_d = LOAD;
      endcase
   end

   always_comb begin
      pattern = 8'hFF;
      case (disp_mode)
         2'd0: if (idx_d <= 3'd1) pattern = 8'hBF;
         2'd1: begin
            if (idx_d == 3'd7)      pattern = seg_code(goods_code[7:4]);
            else if (idx_d == 3'd6) pattern = seg_code(goods_code[3:0]);
            else if (idx_d <= 3'd2) pattern = dec_digit(bcd_ch_q[0], idx_d[1:0]);
         end
         2'd2: begin
            if (idx_d >= 3'd5)      pattern = dec_digit(bcd_ch_q[0], 2'(idx_d - 3'd5));
            else if (idx_d <= 3'd2) pattern = dec_digit(bcd_ch_q[1], idx_d[1:0]);
         end
         default: if (idx_d <= 3'd2) pattern = dec_digit(bcd_ch_q[2], idx_d[1:0]);
      endcase
   end

   // enable and segments load on the same edge so a digit never shows its neighbour's pattern
   always_comb begin
      presc_tc = (presc_q == PW'(SCAN_DIV - 1));
      presc_d  = presc_tc ? '0 : presc_q + PW'(1);
      idx_d    = presc_tc ? idx_q + 3'd1 : idx_q;
      bit_d    = bit_q;
      seg_d    = seg_q;
      if (presc_tc) begin
         bit_d = ~(8'd1 << idx_d);
         seg_d = pattern;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cv_state_q <= LOAD;
         ch_q       <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < 3; i++) bcd_ch_q[i] <= '0;
         presc_q    <= '0;
         idx_q      <= '0;
         bit_q      <= 8'hFF;
         seg_q      <= 8'hFF;
      end else begin
         cv_state_q <= cv_state_d;
         ch_q       <= ch_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         for (int i = 0; i < 3; i++) bcd_ch_q[i] <= bcd_ch_d[i];
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         bit_q      <= bit_d;
         seg_q      <= seg_d;
      end
   end

   assign Bit_select = bit_q;
   assign Seg_select = seg_q;

endmodule

// File: tb/tb_vend_disp_scan.sv
// Bench for vend_disp_scan: cycle-by-cycle decimal display model plus directed literal frames.
module tb_vend_disp_scan;

   localparam int SD = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] mode;
   logic [7:0] gc, need, inp, chg;
   logic [7:0] bit_sel, seg_sel;

   int n_checks = 0;
   int n_fail   = 0;

   vend_disp_scan #(.SCAN_DIV(SD)) dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst_n),
      .disp_mode   (mode),
      .goods_code  (gc),
      .need_money  (need),
      .input_money (inp),
      .change_money(chg),
      .Bit_select  (bit_sel),
      .Seg_select  (seg_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] hexseg(input int v);
      case (v)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
         12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
      endcase
   endfunction

   function automatic logic [7:0] decdig(input int v, input int pos);
      if (pos == 2) return (v < 100) ? 8'hFF : hexseg(v / 100);
      if (pos == 1) return (v < 10) ? 8'hFF : hexseg((v / 10) % 10);
      return hexseg(v % 10);
   endfunction

   function automatic logic [7:0] model_seg(input int d, input int m, input int g,
                                            input int nd, input int in, input int ch);
      case (m)
         0: return (d <= 1) ? 8'hBF : 8'hFF;
         1: begin
            if (d == 7) return hexseg(g / 16);
            if (d == 6) return hexseg(g % 16);
            if (d <= 2) return decdig(nd, d);
            return 8'hFF;
         end
         2: begin
            if (d >= 5) return decdig(nd, d - 5);
            if (d <= 2) return decdig(in, d);
            return 8'hFF;
         end
         default: return (d <= 2) ? decdig(ch, d) : 8'hFF;
      endcase
   endfunction

   // model state: edges since release, last data change, expectation for the current slot
   int          cyc;
   int          last_chg;
   logic [31:0] prev_sig;
   logic [7:0]  slot_exp;
   logic        slot_valid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc        = 0;
         last_chg   = 0;
         slot_valid = 1'b0;
         prev_sig   = {gc, need, inp, chg};
      end else begin
         cyc++;
         if ({gc, need, inp, chg} != prev_sig) last_chg = cyc;
         prev_sig = {gc, need, inp, chg};
         if (cyc % SD == 0) begin
            slot_exp   = model_seg((cyc / SD) % 8, int'(mode), int'(gc), int'(need),
                                   int'(inp), int'(chg));
            slot_valid = (mode == 2'd0) || (cyc - last_chg >= 41);
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] eb;
      if (!rst_n) begin
         chk("rst_bit", bit_sel, 8'hFF);
         chk("rst_seg", seg_sel, 8'hFF);
      end else if (cyc < SD) begin
         chk("pre_bit", bit_sel, 8'hFF);
         chk("pre_seg", seg_sel, 8'hFF);
      end else begin
         eb = 8'd1 << ((cyc / SD) % 8);
         eb = ~eb;
         chk("scan_bit", bit_sel, eb);
         if (slot_valid) chk("scan_seg", seg_sel, slot_exp);
      end
   end

   logic [7:0] frame [8];

   task automatic capture(input int settle);
      for (int i = 0; i < 8; i++) frame[i] = 8'h00;
      repeat (settle) @(negedge clk);
      repeat (10 * SD) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++)
            if (bit_sel == ~(8'd1 << i)) frame[i] = seg_sel;
      end
   endtask

   task automatic check_frame(input string tag, input logic [63:0] exp);
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s_d%0d", tag, i), frame[i], exp[i*8 +: 8]);
   endtask

   logic [7:0] order [9];

   initial begin
      order = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE, 8'hFD};
      rst_n = 1'b0;
      mode  = 2'd0;
      gc    = 8'h00;
      need  = 8'd0;
      inp   = 8'd0;
      chg   = 8'd0;
      repeat (5) begin
         @(negedge clk);
         chk("reset_hold_bit", bit_sel, 8'hFF);
      end
      rst_n = 1'b1;

      for (int c = 1; c < 10 * SD; c++) begin
         @(negedge clk);
         if (c == SD) chk("first_seg_dash", seg_sel, 8'hBF);
         if (c >= SD) chk($sformatf("order_slot%0d", c / SD), bit_sel, order[c / SD - 1]);
      end

      mode = 2'd1; gc = 8'h23; need = 8'd27;
      capture(50);
      check_frame("select", {8'hA4, 8'hB0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA4, 8'hF8});

      mode = 2'd2; need = 8'd100; inp = 8'd5;
      capture(50);
      check_frame("pay", {8'hF9, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92});

      mode = 2'd3; chg = 8'd255;
      capture(50);
      check_frame("chg255", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA4, 8'h92, 8'h92});

      chg = 8'd0;
      capture(40);
      check_frame("chg0", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

      // rapid changes while conversions are in flight; only the settled value may show
      chg = 8'd9;  repeat (3) @(negedge clk);
      chg = 8'd10; repeat (5) @(negedge clk);
      chg = 8'd99;
      capture(50);
      check_frame("chg99", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h90, 8'h90});

      mode = 2'd2; need = 8'd7; inp = 8'd42;
      capture(50);
      check_frame("pay2", {8'hFF, 8'hFF, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hA4});

      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_bit", bit_sel, 8'hFF);
      chk("async_rst_seg", seg_sel, 8'hFF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (SD - 1) @(negedge clk);
      chk("resume_before", bit_sel, 8'hFF);
      @(negedge clk);
      chk("resume_first", bit_sel, 8'hFD);
      repeat (20 * SD) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
